// File: rtl/nor_bus_ctrl.sv
// nor_bus_ctrl: Wishbone-classic slave that turns single 16-bit requests into
// asynchronous NOR flash bus cycles with parameterised setup/pulse/hold/turn
// timing, and synchronises RY/BY# into a pollable ready bit.
module nor_bus_ctrl #(
  parameter  int unsigned RD_WAIT  = 6,
  parameter  int unsigned WR_SETUP = 2,
  parameter  int unsigned WR_PULSE = 3,
  parameter  int unsigned WR_HOLD  = 1,
  parameter  int unsigned TURN     = 2,
  localparam int unsigned AW       = 26,
  localparam int unsigned DW       = 16
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic [AW-1:0] nor_addr_o,
  input  logic [DW-1:0] nor_data_i,
  output logic [DW-1:0] nor_data_o,
  output logic          nor_data_oe,
  output logic          nor_ce_o,
  output logic          nor_oe_o,
  output logic          nor_we_o,
  input  logic          nor_ry_i,
  output logic          nor_ready_o
);

  localparam int unsigned CW = 8;

  // Counter load values: a phase of N cycles loads N-1; a zero setting acts as 1.
  localparam logic [CW-1:0] RD_LOAD   = CW'((RD_WAIT  == 0) ? 0 : RD_WAIT  - 1);
  localparam logic [CW-1:0] WS_LOAD   = CW'((WR_SETUP == 0) ? 0 : WR_SETUP - 1);
  localparam logic [CW-1:0] WP_LOAD   = CW'((WR_PULSE == 0) ? 0 : WR_PULSE - 1);
  localparam logic [CW-1:0] WH_LOAD   = CW'((WR_HOLD  == 0) ? 0 : WR_HOLD  - 1);
  localparam logic [CW-1:0] TURN_LOAD = CW'((TURN     == 0) ? 0 : TURN     - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_TURN
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_abort, w_abort_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [DW-1:0]   r_wdat, w_wdat_nxt;
  logic [DW-1:0]   r_rdat, w_rdat_nxt;
  logic            r_ack, w_ack_nxt;
  logic            r_ce_n, w_ce_n_nxt;
  logic            r_oe_n, w_oe_n_nxt;
  logic            r_we_n, w_we_n_nxt;
  logic            r_doe, w_doe_nxt;
  logic            r_ry_meta, r_ry_sync;
  logic            w_last;
  logic            w_abort_now;

  assign w_last      = (r_cnt == '0);
  // A transaction is abandoned once the master has dropped cyc at any point.
  assign w_abort_now = r_abort | ~wb_cyc_i;

  // State, counter and all bus-facing outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
      r_ack   <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_doe   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
      r_addr  <= w_addr_nxt;
      r_wdat  <= w_wdat_nxt;
      r_rdat  <= w_rdat_nxt;
      r_ack   <= w_ack_nxt;
      r_ce_n  <= w_ce_n_nxt;
      r_oe_n  <= w_oe_n_nxt;
      r_we_n  <= w_we_n_nxt;
      r_doe   <= w_doe_nxt;
    end
  end

  // Next state, phase counter and next strobe values (decoded from next state).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_last ? '0 : r_cnt - CW'(1);
    w_abort_nxt = r_abort;
    w_addr_nxt  = r_addr;
    w_wdat_nxt  = r_wdat;
    w_rdat_nxt  = r_rdat;
    w_ack_nxt   = 1'b0;
    w_ce_n_nxt  = 1'b1;
    w_oe_n_nxt  = 1'b1;
    w_we_n_nxt  = 1'b1;
    w_doe_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_abort_nxt = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          w_addr_nxt = wb_adr_i;
          if (wb_we_i) begin
            w_wdat_nxt  = wb_dat_i;
            w_state_nxt = S_WR_SETUP;
            w_cnt_nxt   = WS_LOAD;
          end else begin
            w_state_nxt = S_RD;
            w_cnt_nxt   = RD_LOAD;
          end
        end
      end
      S_RD: begin
        w_abort_nxt = w_abort_now;
        if (w_last) begin
          w_rdat_nxt  = nor_data_i;
          w_ack_nxt   = ~w_abort_now;
          w_state_nxt = S_TURN;
          w_cnt_nxt   = TURN_LOAD;
        end
      end
      S_WR_SETUP: begin
        w_abort_nxt = w_abort_now;
        if (w_last) begin
          w_state_nxt = S_WR_PULSE;
          w_cnt_nxt   = WP_LOAD;
        end
      end
      S_WR_PULSE: begin
        w_abort_nxt = w_abort_now;
        if (w_last) begin
          w_state_nxt = S_WR_HOLD;
          w_cnt_nxt   = WH_LOAD;
        end
      end
      S_WR_HOLD: begin
        w_abort_nxt = w_abort_now;
        if (w_last) begin
          w_ack_nxt   = ~w_abort_now;
          w_state_nxt = S_TURN;
          w_cnt_nxt   = TURN_LOAD;
        end
      end
      S_TURN: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // OE# and WE# live in disjoint states, so they can never overlap, and DQ
    // is only driven in write states where OE# is high.
    case (w_state_nxt)
      S_RD: begin
        w_ce_n_nxt = 1'b0;
        w_oe_n_nxt = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        w_ce_n_nxt = 1'b0;
        w_doe_nxt  = 1'b1;
      end
      S_WR_PULSE: begin
        w_ce_n_nxt = 1'b0;
        w_we_n_nxt = 1'b0;
        w_doe_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  // Two-flop synchroniser for the asynchronous RY/BY# pin.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_ry_meta <= 1'b0;
      r_ry_sync <= 1'b0;
    end else begin
      r_ry_meta <= nor_ry_i;
      r_ry_sync <= r_ry_meta;
    end
  end

  assign wb_dat_o    = r_rdat;
  assign wb_ack_o    = r_ack;
  assign nor_addr_o  = r_addr;
  assign nor_data_o  = r_wdat;
  assign nor_data_oe = r_doe;
  assign nor_ce_o    = r_ce_n;
  assign nor_oe_o    = r_oe_n;
  assign nor_we_o    = r_we_n;
  assign nor_ready_o = r_ry_sync;

endmodule
